// File: rtl/rpn_op_sequencer_if.sv
// Token / stack-ALU opcode / result bundle for rpn_op_sequencer.
// master: the sequencer. slave: the token source, stack ALU and result sink.
interface rpn_op_sequencer_if #(
  parameter int N     = 4,
  parameter int DEPTH = 8
);
  localparam int D = $clog2(DEPTH + 1);

  logic         tok_valid;
  logic         tok_ready;
  logic [1:0]   tok_kind;
  logic [N-1:0] tok_data;

  logic         alu_strobe;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_data;
  logic [N-1:0] alu_result;
  logic         alu_overflow;

  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_ovf;

  logic         err;
  logic [1:0]   err_code;
  logic [D-1:0] depth;

  modport master (
    input  tok_valid, tok_kind, tok_data, alu_result, alu_overflow, res_ready,
    output tok_ready, alu_strobe, alu_opcode, alu_data,
           res_valid, res_data, res_ovf, err, err_code, depth
  );

  modport slave (
    output tok_valid, tok_kind, tok_data, alu_result, alu_overflow, res_ready,
    input  tok_ready, alu_strobe, alu_opcode, alu_data,
           res_valid, res_data, res_ovf, err, err_code, depth
  );
endinterface

// File: rtl/rpn_op_sequencer.sv
// RPN token sequencer driving a downstream stack ALU with one-cycle opcode
// strobes, tracking a shadow stack depth and rejecting malformed expressions.
// Optional feature: define RPN_ERR_FLUSH_EN to make ERROR recoverable
// (discard tokens up to an end token, then pop the ALU stack empty in DRAIN).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a token; all stack checks done here
// ISSUE   | one-cycle strobe of the latched opcode/data to the ALU
// WAIT    | ALU result/overflow valid; fold overflow or capture result
// RESULT  | expression value presented until res_ready
// ERROR   | malformed expression; err/err_code held
// DRAIN   | (RPN_ERR_FLUSH_EN) pop ALU stack, one pop per two cycles
module rpn_op_sequencer #(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  rpn_op_sequencer_if.master  bus
);
  localparam int D = $clog2(DEPTH + 1);
  localparam logic [D-1:0] DEPTH_MAX = D'(DEPTH);

  localparam logic [1:0] K_OPND = 2'b00;
  localparam logic [1:0] K_ADD  = 2'b01;
  localparam logic [1:0] K_MUL  = 2'b10;
  localparam logic [1:0] K_END  = 2'b11;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] E_FULL  = 2'b01;
  localparam logic [1:0] E_UNDER = 2'b10;
  localparam logic [1:0] E_END   = 2'b11;

`ifdef RPN_ERR_FLUSH_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESULT, S_ERROR, S_DRAIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESULT, S_ERROR
  } state_t;
`endif

  state_t       state_q, state_nxt;
  logic [D-1:0] depth_q, depth_nxt;
  logic [2:0]   op_q, op_nxt;
  logic [N-1:0] data_q, data_nxt;
  logic         ovf_acc_q, ovf_acc_nxt;
  logic [N-1:0] res_data_q, res_data_nxt;
  logic         res_ovf_q, res_ovf_nxt;
  logic         err_q, err_nxt;
  logic [1:0]   err_code_q, err_code_nxt;
`ifdef RPN_ERR_FLUSH_EN
  logic         gap_q, gap_nxt;
`endif

  logic         tok_ready_c;
  logic         strobe_c;
  logic [2:0]   opcode_c;
  logic [N-1:0] alu_data_c;

  // State and datapath registers; reset abandons everything at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      depth_q    <= '0;
      op_q       <= OP_NONE;
      data_q     <= '0;
      ovf_acc_q  <= 1'b0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
`ifdef RPN_ERR_FLUSH_EN
      gap_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_nxt;
      depth_q    <= depth_nxt;
      op_q       <= op_nxt;
      data_q     <= data_nxt;
      ovf_acc_q  <= ovf_acc_nxt;
      res_data_q <= res_data_nxt;
      res_ovf_q  <= res_ovf_nxt;
      err_q      <= err_nxt;
      err_code_q <= err_code_nxt;
`ifdef RPN_ERR_FLUSH_EN
      gap_q      <= gap_nxt;
`endif
    end
  end

  // Next-state, depth bookkeeping and strobe generation.
  always_comb begin
    state_nxt    = state_q;
    depth_nxt    = depth_q;
    op_nxt       = op_q;
    data_nxt     = data_q;
    ovf_acc_nxt  = ovf_acc_q;
    res_data_nxt = res_data_q;
    res_ovf_nxt  = res_ovf_q;
    err_nxt      = err_q;
    err_code_nxt = err_code_q;
`ifdef RPN_ERR_FLUSH_EN
    gap_nxt      = gap_q;
`endif
    tok_ready_c  = 1'b0;
    strobe_c     = 1'b0;
    opcode_c     = OP_NONE;
    alu_data_c   = '0;

    case (state_q)
      S_IDLE: begin
        tok_ready_c = 1'b1;
        if (bus.tok_valid) begin
          // Checks use the depth before this token; errors leave depth as is.
          case (bus.tok_kind)
            K_OPND: begin
              if (depth_q == DEPTH_MAX) begin
                err_nxt      = 1'b1;
                err_code_nxt = E_FULL;
                state_nxt    = S_ERROR;
              end else begin
                op_nxt    = OP_PUSH;
                data_nxt  = bus.tok_data;
                depth_nxt = depth_q + D'(1);
                state_nxt = S_ISSUE;
              end
            end
            K_ADD, K_MUL: begin
              if (depth_q < D'(2)) begin
                err_nxt      = 1'b1;
                err_code_nxt = E_UNDER;
                state_nxt    = S_ERROR;
              end else begin
                op_nxt    = (bus.tok_kind == K_ADD) ? OP_ADD : OP_MUL;
                data_nxt  = '0;
                depth_nxt = depth_q - D'(1);
                state_nxt = S_ISSUE;
              end
            end
            K_END: begin
              if (depth_q != D'(1)) begin
                err_nxt      = 1'b1;
                err_code_nxt = E_END;
                state_nxt    = S_ERROR;
              end else begin
                op_nxt    = OP_POP;
                data_nxt  = '0;
                depth_nxt = '0;
                state_nxt = S_ISSUE;
              end
            end
            default: state_nxt = S_IDLE;
          endcase
        end
      end

      S_ISSUE: begin
        strobe_c   = 1'b1;
        opcode_c   = op_q;
        alu_data_c = data_q;
        state_nxt  = S_WAIT;
      end

      S_WAIT: begin
        case (op_q)
          OP_ADD, OP_MUL: begin
            ovf_acc_nxt = ovf_acc_q | bus.alu_overflow;
            state_nxt   = S_IDLE;
          end
          OP_POP: begin
            res_data_nxt = bus.alu_result;
            res_ovf_nxt  = ovf_acc_q;
            state_nxt    = S_RESULT;
          end
          default: state_nxt = S_IDLE;
        endcase
      end

      S_RESULT: begin
        if (bus.res_ready) begin
          ovf_acc_nxt = 1'b0;
          state_nxt   = S_IDLE;
        end
      end

      S_ERROR: begin
`ifdef RPN_ERR_FLUSH_EN
        // Swallow the rest of the bad expression up to its end token.
        tok_ready_c = 1'b1;
        if (bus.tok_valid && (bus.tok_kind == K_END)) begin
          gap_nxt   = 1'b0;
          state_nxt = S_DRAIN;
        end
`endif
      end

`ifdef RPN_ERR_FLUSH_EN
      S_DRAIN: begin
        // Empty the ALU stack so the next expression starts clean.
        if (depth_q == '0) begin
          err_nxt      = 1'b0;
          err_code_nxt = 2'b00;
          ovf_acc_nxt  = 1'b0;
          state_nxt    = S_IDLE;
        end else if (!gap_q) begin
          strobe_c  = 1'b1;
          opcode_c  = OP_POP;
          depth_nxt = depth_q - D'(1);
          gap_nxt   = 1'b1;
        end else begin
          gap_nxt = 1'b0;
        end
      end
`endif

      default: state_nxt = S_IDLE;
    endcase
  end

  // Drive the interface outputs.
  assign bus.tok_ready  = tok_ready_c;
  assign bus.alu_strobe = strobe_c;
  assign bus.alu_opcode = opcode_c;
  assign bus.alu_data   = alu_data_c;
  assign bus.res_valid  = (state_q == S_RESULT);
  assign bus.res_data   = res_data_q;
  assign bus.res_ovf    = res_ovf_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.depth      = depth_q;

endmodule

// File: tb/tb_rpn_op_sequencer.sv
// Directed bench for rpn_op_sequencer with a behavioural stack-ALU model.
// Define RPN_ERR_FLUSH_EN for the bench and RTL together to cover recovery.
`define CHK(tag, obs, exp) chk(tag, 32'(obs), 32'(exp))

module tb_rpn_op_sequencer;
  localparam int N = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rpn_op_sequencer_if #(.N(N), .DEPTH(DEPTH)) bus();
  rpn_op_sequencer #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [2:0] log_op[0:63];
  logic [3:0] log_data[0:63];
  int         log_cyc[0:63];
  int         log_n = 0;

  // Strobe log: opcode, data and cycle of every ALU strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.alu_strobe === 1'b1) begin
      log_op[log_n % 64]   <= bus.alu_opcode;
      log_data[log_n % 64] <= bus.alu_data;
      log_cyc[log_n % 64]  <= cyc;
      log_n                <= log_n + 1;
    end
  end

  // Stack ALU model: result/overflow valid the cycle after a strobe.
  logic [3:0] stk[0:15];
  int sp = 0;
  always @(posedge clk) begin
    int a, b, r;
    if (rst) begin
      sp = 0;
      bus.alu_result   <= '0;
      bus.alu_overflow <= 1'b0;
    end else if (bus.alu_strobe === 1'b1) begin
      case (bus.alu_opcode)
        3'b110: begin
          if (sp < 16) begin stk[sp] = bus.alu_data; sp = sp + 1; end
          bus.alu_result   <= bus.alu_data;
          bus.alu_overflow <= 1'b0;
        end
        3'b100, 3'b101: begin
          if (sp >= 2) begin
            a = int'($signed(stk[sp-2]));
            b = int'($signed(stk[sp-1]));
            r = (bus.alu_opcode == 3'b100) ? a + b : a * b;
            sp = sp - 1;
            stk[sp-1] = r[3:0];
            bus.alu_result   <= r[3:0];
            bus.alu_overflow <= (r > 7) || (r < -8);
          end
        end
        3'b111: begin
          if (sp >= 1) begin
            bus.alu_result <= stk[sp-1];
            sp = sp - 1;
          end
          bus.alu_overflow <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.tok_valid = 1'b0;
    bus.tok_kind  = 2'b00;
    bus.tok_data  = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Offer one token and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [1:0] k, input logic [3:0] d);
    int n = 0;
    bus.tok_valid = 1'b1;
    bus.tok_kind  = k;
    bus.tok_data  = d;
    while (bus.tok_ready !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    `CHK("send_accept", n < 30, 1);
    @(posedge clk); #1;
    bus.tok_valid = 1'b0;
    bus.tok_kind  = 2'b00;
    bus.tok_data  = '0;
  endtask

  task automatic wait_res();
    int n = 0;
    while (bus.res_valid !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    `CHK("res_valid_seen", n < 30, 1);
  endtask

  task automatic take_res();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    int base;
    int n;

    // Reset state
    do_reset();
    `CHK("rst_tok_ready", bus.tok_ready, 1);
    `CHK("rst_strobe", bus.alu_strobe, 0);
    `CHK("rst_opcode", bus.alu_opcode, 0);
    `CHK("rst_alu_data", bus.alu_data, 0);
    `CHK("rst_res_valid", bus.res_valid, 0);
    `CHK("rst_res_data", bus.res_data, 0);
    `CHK("rst_err", bus.err, 0);
    `CHK("rst_depth", bus.depth, 0);

    // T1: 3 4 + end -> 7
    base = log_n;
    send(2'b00, 4'd3);
    send(2'b00, 4'd4);
    `CHK("t1_depth2", bus.depth, 2);
    send(2'b01, 4'd0);
    `CHK("t1_depth1", bus.depth, 1);
    send(2'b11, 4'd0);
    wait_res();
    checks++;
    if (bus.res_data !== 4'd7) begin
      errors++;
      $error("FAIL t1_res_data observed=%0h expected=7", bus.res_data);
    end
    checks++;
    if (bus.res_ovf !== 1'b0) begin
      errors++;
      $error("FAIL t1_res_ovf observed=%0h expected=0", bus.res_ovf);
    end
    `CHK("t1_depth0", bus.depth, 0);
    `CHK("t1_nstrobe", log_n - base, 4);
    `CHK("t1_op0", log_op[base], 3'b110);
    `CHK("t1_d0", log_data[base], 3);
    `CHK("t1_op1", log_op[base+1], 3'b110);
    `CHK("t1_d1", log_data[base+1], 4);
    `CHK("t1_op2", log_op[base+2], 3'b100);
    `CHK("t1_op3", log_op[base+3], 3'b111);
    `CHK("t1_gap01", log_cyc[base+1] - log_cyc[base], 3);
    `CHK("t1_gap12", log_cyc[base+2] - log_cyc[base+1], 3);
    `CHK("t1_gap23", log_cyc[base+3] - log_cyc[base+2], 3);
    take_res();
    `CHK("t1_idle_ready", bus.tok_ready, 1);

    // T2: 5 6 + end -> 4'hB with signed overflow, result held under backpressure
    do_reset();
    send(2'b00, 4'd5);
    send(2'b00, 4'd6);
    send(2'b01, 4'd0);
    send(2'b11, 4'd0);
    wait_res();
    for (int i = 0; i < 5; i++) begin
      `CHK("t2_hold_valid", bus.res_valid, 1);
      checks++;
      if (bus.res_data !== 4'hB) begin
        errors++;
        $error("FAIL t2_hold_data observed=%0h expected=b", bus.res_data);
      end
      checks++;
      if (bus.res_ovf !== 1'b1) begin
        errors++;
        $error("FAIL t2_hold_ovf observed=%0h expected=1", bus.res_ovf);
      end
      `CHK("t2_hold_tok_ready", bus.tok_ready, 0);
      @(posedge clk); #1;
    end
    take_res();
    `CHK("t2_released", bus.res_valid, 0);
    `CHK("t2_ready_again", bus.tok_ready, 1);

    // T3: add as the first token -> underflow error, no strobe
    do_reset();
    base = log_n;
    send(2'b01, 4'd0);
    repeat (4) begin @(posedge clk); #1; end
    `CHK("t3_err", bus.err, 1);
    checks++;
    if (bus.err_code !== 2'b10) begin
      errors++;
      $error("FAIL t3_code observed=%0h expected=2", bus.err_code);
    end
    `CHK("t3_depth", bus.depth, 0);
    `CHK("t3_nostrobe", log_n - base, 0);
`ifdef RPN_ERR_FLUSH_EN
    `CHK("t3_tok_ready", bus.tok_ready, 1);
`else
    `CHK("t3_tok_ready", bus.tok_ready, 0);
`endif

    // T4: nine operands -> eight pushes then stack-full error
    do_reset();
    base = log_n;
    for (int i = 1; i <= 8; i++) send(2'b00, 4'(i));
    repeat (2) begin @(posedge clk); #1; end
    `CHK("t4_depth_full", bus.depth, 8);
    send(2'b00, 4'd9);
    repeat (3) begin @(posedge clk); #1; end
    `CHK("t4_err", bus.err, 1);
    checks++;
    if (bus.err_code !== 2'b01) begin
      errors++;
      $error("FAIL t4_code observed=%0h expected=1", bus.err_code);
    end
    `CHK("t4_depth", bus.depth, 8);
    `CHK("t4_npush", log_n - base, 8);
    for (int i = 0; i < 8; i++) `CHK("t4_push_op", log_op[base+i], 3'b110);
    `CHK("t4_last_data", log_data[base+7], 8);

    // T4b: 2 3 end -> end with depth != 1
    do_reset();
    send(2'b00, 4'd2);
    send(2'b00, 4'd3);
    send(2'b11, 4'd0);
    repeat (2) begin @(posedge clk); #1; end
    `CHK("t4b_err", bus.err, 1);
    `CHK("t4b_code", bus.err_code, 2'b11);
    `CHK("t4b_depth", bus.depth, 2);

    // T5: reset during the WAIT of a push
    do_reset();
    send(2'b00, 4'd5);
    `CHK("t5_issue_strobe", bus.alu_strobe, 1);
    @(posedge clk); #1;
    `CHK("t5_wait_strobe", bus.alu_strobe, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    `CHK("t5_depth", bus.depth, 0);
    `CHK("t5_strobe", bus.alu_strobe, 0);
    `CHK("t5_opcode", bus.alu_opcode, 0);
    `CHK("t5_err", bus.err, 0);
    `CHK("t5_res_valid", bus.res_valid, 0);
    `CHK("t5_tok_ready", bus.tok_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef RPN_ERR_FLUSH_EN
    // T6: recover from an end-with-depth-2 error
    do_reset();
    send(2'b00, 4'd1);
    send(2'b00, 4'd2);
    send(2'b11, 4'd0);
    repeat (2) begin @(posedge clk); #1; end
    `CHK("t6_code", bus.err_code, 2'b11);
    base = log_n;
    send(2'b00, 4'd7);
    send(2'b11, 4'd0);
    n = 0;
    while (bus.err !== 1'b0 && n < 30) begin @(posedge clk); #1; n++; end
    `CHK("t6_err_cleared", n < 30, 1);
    `CHK("t6_npop", log_n - base, 2);
    `CHK("t6_pop0", log_op[base], 3'b111);
    `CHK("t6_pop1", log_op[base+1], 3'b111);
    `CHK("t6_code_clr", bus.err_code, 0);
    `CHK("t6_depth", bus.depth, 0);
    @(posedge clk); #1;
    `CHK("t6_idle", bus.tok_ready, 1);
    send(2'b00, 4'd2);
    send(2'b00, 4'd3);
    send(2'b10, 4'd0);
    send(2'b11, 4'd0);
    wait_res();
    checks++;
    if (bus.res_data !== 4'd6) begin
      errors++;
      $error("FAIL t6_res_data observed=%0h expected=6", bus.res_data);
    end
    `CHK("t6_res_ovf", bus.res_ovf, 0);
    take_res();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
